// File: rtl/data_block_memory_pkg.sv
// Shared types and constants for the block-granular data memory.
package data_block_memory_pkg;

  localparam int BLOCK_W         = 128;
  localparam int ADDR_W          = 28;
  localparam int DEFAULT_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_block_memory.sv
// Multi-cycle 128-bit block memory behind the data cache; BUSYWAIT stalls
// the requester from acceptance until the access has completed.
module data_block_memory
  import data_block_memory_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [BLOCK_W-1:0] WRITEDATA,
  output logic [BLOCK_W-1:0] READDATA,
  output logic               BUSYWAIT
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   op_write;
  logic [ADDR_BITS-1:0]   idx;
  logic [BLOCK_W-1:0]     wdata;
  logic [BLOCK_W-1:0]     mem [DEPTH];

  // Upper address bits alias onto the same storage and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDRESS[ADDR_W-1:ADDR_BITS];

  always_comb begin
    BUSYWAIT = 1'b0;
    case (state)
      IDLE:    BUSYWAIT = READ | WRITE;
      BUSY:    BUSYWAIT = 1'b1;
      default: BUSYWAIT = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      READDATA <= '0;
      for (int i = 0; i < DEPTH; i++) mem[ADDR_BITS'(i)] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // WRITE wins when both request lines are high.
          if (READ || WRITE) begin
            op_write <= WRITE;
            idx      <= ADDRESS[ADDR_BITS-1:0];
            wdata    <= WRITEDATA;
            cnt      <= CNT_W'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (op_write) mem[idx] <= wdata;
            else          READDATA <= mem[idx];
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_block_memory.sv
// Directed scoreboard bench: stimulus queues the expected READDATA for each
// access, a negedge monitor pops and compares on every completion.
module tb_data_block_memory;

  logic         CLK;
  logic         RESET;
  logic         READ;
  logic         WRITE;
  logic [27:0]  ADDRESS;
  logic [127:0] WRITEDATA;
  logic [127:0] READDATA;
  logic         BUSYWAIT;

  int total = 0;
  int bad   = 0;
  int n_exp = 0;
  int n_done = 0;
  logic [127:0] sb_q[$];
  logic prev_busy = 1'b0;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DA = {16{8'hA5}};
  localparam logic [127:0] DX = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] DF = {16{8'hFF}};
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;

  data_block_memory #(.ADDR_BITS(6), .LATENCY(5)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
    .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Completion = BUSYWAIT falls while the request is still held (DONE cycle).
  always @(negedge CLK) begin
    if (prev_busy === 1'b1 && BUSYWAIT === 1'b0 && (READ || WRITE)) begin
      n_done++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_completion: got READDATA %h expected no completion", READDATA);
      end else begin
        check("readdata", READDATA, sb_q.pop_front());
      end
    end
    prev_busy = BUSYWAIT;
  end

  // One access held until BUSYWAIT drops; inputs are scrambled after acceptance.
  task automatic access(input bit rd, input bit wr, input logic [27:0] addr,
                        input logic [127:0] data, input logic [127:0] exp_rd,
                        input string name);
    int n;
    sb_q.push_back(exp_rd);
    n_exp++;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
    @(posedge CLK); #1;
    ADDRESS = ~addr; WRITEDATA = ~data;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (!BUSYWAIT) break;
      n++;
      @(posedge CLK); #1;
    end
    check({name, "_busy_edges"}, 128'(n), 128'd5);
    @(negedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    int first, second, lows;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    check("reset_busywait", 128'(BUSYWAIT), 128'd0);
    check("reset_readdata", READDATA, 128'd0);

    access(1, 0, 28'h10, '0, 128'd0, "rd_empty");
    access(0, 1, 28'h3, D1, 128'd0, "wr_3");
    access(1, 0, 28'h3, '0, D1, "rd_3");
    access(0, 1, 28'h45, DA, D1, "wr_45");
    access(1, 0, 28'h6, '0, 128'd0, "rd_6");
    access(1, 0, 28'h5, '0, DA, "rd_5_alias");
    access(1, 1, 28'h7, DX, DA, "rw_7");
    access(1, 0, 28'h7, '0, DX, "rd_7");

    // Abort a write with a reset on the third BUSY edge.
    @(posedge CLK); #1;
    WRITE = 1'b1; ADDRESS = 28'h2; WRITEDATA = DF;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1; WRITE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("abort_busywait", 128'(BUSYWAIT), 128'd0);
    check("abort_readdata", READDATA, 128'd0);
    access(1, 0, 28'h2, '0, 128'd0, "rd_2_after_abort");
    access(1, 0, 28'h3, '0, 128'd0, "rd_3_after_reset");

    // Back-to-back: READ held through DONE gives two accesses, one low cycle between.
    access(0, 1, 28'h9, D2, 128'd0, "wr_9");
    sb_q.push_back(D2); sb_q.push_back(D2);
    n_exp += 2;
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = 28'h9;
    first = -1; second = -1; lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      if (!BUSYWAIT) begin
        lows++;
        if (lows == 1) first = i;
        else begin second = i; break; end
      end
    end
    @(negedge CLK); #1;
    READ = 1'b0;
    check("b2b_first_done", 128'(first), 128'd5);
    check("b2b_high_gap", 128'(second - first - 1), 128'd6);

    repeat (3) @(posedge CLK);
    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    check("completion_count", 128'(n_done), 128'(n_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
